// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, flag and status controller for a 2^K-entry synchronous FIFO.
// The FIFO storage is an external RAM with a registered read port.
// Occupancy is tracked both as a count and as a three-state FSM (empty / mid / full).
// full and empty come from the FSM state. The remaining status outputs come from the
// next occupancy value, so they never lag a cycle behind.
module fifo_ctrl #(
  parameter int unsigned K      = 3,
  parameter int unsigned AF_LVL = 2**K - 1,
  parameter int unsigned AE_LVL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         rd_en,
  output logic         ram_we,
  output logic         ram_re,
  output logic [K-1:0] wr_addr,
  output logic [K-1:0] rd_addr,
  output logic         rd_valid,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [K:0]   count,
  output logic         overflow,
  output logic         underflow
);

  localparam logic [K:0] Depth = {1'b1, {K{1'b0}}};
  localparam logic [K:0] AfLvl = (K+1)'(AF_LVL);
  localparam logic [K:0] AeLvl = (K+1)'(AE_LVL);

  typedef enum logic [1:0] {StEmpty, StMid, StFull} state_e;

  state_e     state;
  logic [K:0] wr_ptr;
  logic [K:0] rd_ptr;
  logic [K:0] count_next;
  logic       acc_wr;
  logic       acc_rd;

  // Accepted requests and the next occupancy value.
  // Rejected requests only affect the sticky error flags.
  always_comb begin
    acc_wr     = wr_en & ~full;
    acc_rd     = rd_en & ~empty;
    count_next = count + {{K{1'b0}}, acc_wr} - {{K{1'b0}}, acc_rd};
  end

  assign ram_we  = acc_wr;
  assign ram_re  = acc_rd;
  assign wr_addr = wr_ptr[K-1:0];
  assign rd_addr = rd_ptr[K-1:0];

  // Update pointers, occupancy, registered status and the occupancy FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StEmpty;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      // Pointers carry an extra wrap bit, so they wrap naturally modulo 2^(K+1).
      wr_ptr       <= wr_ptr + {{K{1'b0}}, acc_wr};
      rd_ptr       <= rd_ptr + {{K{1'b0}}, acc_rd};
      count        <= count_next;
      almost_full  <= (count_next >= AfLvl);
      almost_empty <= (count_next <= AeLvl);
      // The RAM read port is registered, so read data is valid one cycle after acceptance.
      rd_valid     <= acc_rd;
      overflow     <= overflow | (wr_en & full);
      underflow    <= underflow | (rd_en & empty);
      case (state)
        StEmpty: begin
          // Only a write can be accepted while empty, so there is no fall-through read.
          if (acc_wr) begin
            state <= StMid;
            empty <= 1'b0;
          end
        end
        StMid: begin
          if (count_next == '0) begin
            state <= StEmpty;
            empty <= 1'b1;
          end else if (count_next == Depth) begin
            state <= StFull;
            full  <= 1'b1;
          end
        end
        StFull: begin
          if (acc_rd) begin
            state <= StMid;
            full  <= 1'b0;
          end
        end
        default: begin
          state <= StEmpty;
          full  <= 1'b0;
          empty <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Testbench for fifo_ctrl (K=3): directed scenarios plus randomized traffic against an
// occupancy/pointer reference model.
module tb_fifo_ctrl;

  localparam int K     = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 7;
  localparam int AE    = 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic         ram_we, ram_re, rd_valid, full, empty;
  logic         almost_full, almost_empty, overflow, underflow;
  logic [K-1:0] wr_addr, rd_addr;
  logic [K:0]   count;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: occupancy, unbounded-style pointers reduced modulo 2*DEPTH, and sticky bits.
  int m_count = 0;
  int m_wp    = 0;
  int m_rp    = 0;
  bit m_ovf   = 0;
  bit m_unf   = 0;
  bit m_rv    = 0;

  fifo_ctrl #(.K(K)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_we       (ram_we),
    .ram_re       (ram_re),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Drive request inputs and let the combinational outputs settle.
  task automatic apply(input logic w, input logic r);
    wr_en = w;
    rd_en = r;
    #1;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    bit aw, ar;
    @(posedge clk);
    if (rst) begin
      m_count = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0; m_rv = 0;
    end else begin
      aw = wr_en && (m_count < DEPTH);
      ar = rd_en && (m_count > 0);
      if (wr_en && m_count == DEPTH) m_ovf = 1;
      if (rd_en && m_count == 0) m_unf = 1;
      m_wp    = (m_wp + int'(aw)) % (2 * DEPTH);
      m_rp    = (m_rp + int'(ar)) % (2 * DEPTH);
      m_count = m_count + int'(aw) - int'(ar);
      m_rv    = ar;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(1'b0, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    apply(1'b0, 1'b0);
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_vec++; if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
      n_err++; $display("FAIL reset_flags: got %b want 1100", {empty, almost_empty, full, almost_full});
    end
    n_vec++; if ({overflow, underflow, rd_valid, ram_we, ram_re} !== 5'b0) begin
      n_err++; $display("FAIL reset_misc: got %b want 00000", {overflow, underflow, rd_valid, ram_we, ram_re});
    end
    tick();
    n_vec++; if ({count, empty, rd_valid, wr_addr, rd_addr} !== {4'd0, 1'b1, 1'b0, 3'd0, 3'd0}) begin
      n_err++; $display("FAIL idle_state: got %h", {count, empty, rd_valid, wr_addr, rd_addr});
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 1'b0);
      n_vec++; if ({ram_we, wr_addr} !== {1'b1, 3'(i)}) begin
        n_err++; $display("FAIL fill_addr[%0d]: got we=%b addr=%0d want we=1 addr=%0d", i, ram_we, wr_addr, i);
      end
      tick();
      n_vec++; if ({count, almost_full, full} !== {4'(i + 1), (i + 1) >= AF, i == DEPTH - 1}) begin
        n_err++; $display("FAIL fill_flags[%0d]: got count=%0d af=%b full=%b", i, count, almost_full, full);
      end
    end
    apply(1'b1, 1'b0);
    n_vec++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL fill_extra_we: got %b want 0", ram_we); end
    tick();
    n_vec++; if ({overflow, wr_addr, count, full} !== {1'b1, 3'd0, 4'd8, 1'b1}) begin
      n_err++; $display("FAIL fill_overflow: got ovf=%b addr=%0d count=%0d full=%b want 1 0 8 1",
                        overflow, wr_addr, count, full);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b0, 1'b1);
      n_vec++; if ({ram_re, rd_addr} !== {1'b1, 3'(i)}) begin
        n_err++; $display("FAIL drain_addr[%0d]: got re=%b addr=%0d want re=1 addr=%0d", i, ram_re, rd_addr, i);
      end
      tick();
      n_vec++; if ({rd_valid, empty, count} !== {1'b1, i == DEPTH - 1, 4'(DEPTH - 1 - i)}) begin
        n_err++; $display("FAIL drain_flags[%0d]: got rv=%b empty=%b count=%0d", i, rd_valid, empty, count);
      end
    end
    apply(1'b0, 1'b1);
    n_vec++; if (ram_re !== 1'b0) begin n_err++; $display("FAIL drain_extra_re: got %b want 0", ram_re); end
    tick();
    n_vec++; if ({underflow, rd_valid, empty} !== 3'b101) begin
      n_err++; $display("FAIL drain_underflow: got unf=%b rv=%b empty=%b want 1 0 1", underflow, rd_valid, empty);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin apply(1'b1, 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin apply(1'b0, 1'b1); tick(); end
    for (int i = 0; i < DEPTH; i++) begin
      apply(1'b1, 1'b0);
      n_vec++; if (wr_addr !== 3'((5 + i) % DEPTH)) begin
        n_err++; $display("FAIL wrap_addr[%0d]: got %0d want %0d", i, wr_addr, (5 + i) % DEPTH);
      end
      tick();
    end
    apply(1'b0, 1'b0);
    n_vec++; if ({full, wr_addr, rd_addr, count} !== {1'b1, 3'd5, 3'd5, 4'd8}) begin
      n_err++; $display("FAIL wrap_full: got full=%b wa=%0d ra=%0d count=%0d want 1 5 5 8",
                        full, wr_addr, rd_addr, count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin apply(1'b1, 1'b0); tick(); end
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b1);
      tick();
      n_vec++; if (count !== 4'd4) begin n_err++; $display("FAIL simul_count[%0d]: got %0d want 4", i, count); end
    end
    n_vec++; if ({wr_addr, rd_addr} !== {3'd6, 3'd2}) begin
      n_err++; $display("FAIL simul_ptrs: got wa=%0d ra=%0d want 6 2", wr_addr, rd_addr);
    end
    for (int i = 0; i < 4; i++) begin apply(1'b1, 1'b0); tick(); end
    apply(1'b1, 1'b1);
    n_vec++; if ({ram_we, ram_re} !== 2'b01) begin
      n_err++; $display("FAIL simul_full_en: got we/re=%b want 01", {ram_we, ram_re});
    end
    tick();
    n_vec++; if ({count, overflow, full} !== {4'd7, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL simul_full: got count=%0d ovf=%b full=%b want 7 1 0", count, overflow, full);
    end
    for (int i = 0; i < 7; i++) begin apply(1'b0, 1'b1); tick(); end
    apply(1'b1, 1'b1);
    n_vec++; if ({ram_we, ram_re} !== 2'b10) begin
      n_err++; $display("FAIL simul_empty_en: got we/re=%b want 10", {ram_we, ram_re});
    end
    tick();
    n_vec++; if ({count, underflow, empty, rd_valid} !== {4'd1, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL simul_empty: got count=%0d unf=%b empty=%b rv=%b want 1 1 0 0",
                        count, underflow, empty, rd_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    apply(1'b0, 1'b1); tick();
    for (int i = 0; i < DEPTH + 1; i++) begin apply(1'b1, 1'b0); tick(); end
    for (int i = 0; i < 2; i++) begin apply(1'b0, 1'b1); tick(); end
    n_vec++; if ({count, overflow, underflow} !== {4'd6, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL rstmid_pre: got count=%0d ovf=%b unf=%b want 6 1 1", count, overflow, underflow);
    end
    apply(1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    apply(1'b0, 1'b0);
    n_vec++; if ({count, empty, full, overflow, underflow, wr_addr, rd_addr} !==
                 {4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0}) begin
      n_err++; $display("FAIL rstmid_post: got count=%0d empty=%b full=%b ovf=%b unf=%b wa=%0d ra=%0d",
                        count, empty, full, overflow, underflow, wr_addr, rd_addr);
    end
  endtask

  task automatic test_random();
    logic [7:0]  exp_pre;
    logic [10:0] exp_post;
    int          pw;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      pw = (c / 100) % 2 == 0 ? 70 : 30;
      rst = ($urandom_range(79) == 0);
      apply($urandom_range(99) < pw, $urandom_range(99) < 50);
      exp_pre = {wr_en && (m_count < DEPTH), rd_en && (m_count > 0), 3'(m_wp % DEPTH), 3'(m_rp % DEPTH)};
      n_vec++; if ({ram_we, ram_re, wr_addr, rd_addr} !== exp_pre) begin
        n_err++; $display("FAIL rand_pre[%0d]: got %h want %h", c, {ram_we, ram_re, wr_addr, rd_addr}, exp_pre);
      end
      tick();
      rst = 1'b0;
      exp_post = {4'(m_count), m_count == DEPTH, m_count == 0, m_count >= AF, m_count <= AE, m_ovf, m_unf, m_rv};
      n_vec++; if ({count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid} !== exp_post) begin
        n_err++; $display("FAIL rand_post[%0d]: got %b want %b", c,
                          {count, full, empty, almost_full, almost_empty, overflow, underflow, rd_valid}, exp_post);
      end
      // Full and empty both imply equal low address bits.
      n_vec++; if ((full || empty) && (wr_addr !== rd_addr)) begin
        n_err++; $display("FAIL rand_invariant[%0d]: got wa=%0d ra=%0d want equal", c, wr_addr, rd_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
